// File: rtl/gol_pkg.sv
// -----------------------------------------------------------------------------
// gol_pkg
//   Shared types and sizing helpers for the Game-of-Life board sequencer.
//   - gol_seq_state_t : sequencer FSM states
//   - row_idx_w()     : width of the interior row index (minimum 1 bit)
//   - cnt_w()         : width of a counter that must hold 0..n-1 (minimum 1 bit)
// -----------------------------------------------------------------------------
package gol_pkg;

  typedef enum logic [1:0] {
    CLEAR    = 2'd0,
    IDLE     = 2'd1,
    LOAD     = 2'd2,
    STEP_REQ = 2'd3
  } gol_seq_state_t;

  // Interior rows exclude the one-cell border at top and bottom.
  function automatic int row_idx_w(input int height);
    int rows;
    rows = height - 2;
    if (rows <= 1) begin
      return 1;
    end else begin
      return $clog2(rows);
    end
  endfunction

  function automatic int cnt_w(input int n);
    if (n <= 1) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/gol_btn_cond.sv
// -----------------------------------------------------------------------------
// gol_btn_cond
//   Conditions one raw active-low push button: 2-FF synchroniser, debounce
//   (a new level is accepted after DEBOUNCE consecutive differing samples) and
//   a single-cycle press pulse on the accepted high-to-low transition.
//   Holding the button produces exactly one pulse; release produces none.
// Parameters
//   DEBOUNCE   samples a new synced level must hold before acceptance (>=1)
// Ports
//   clk        in   system clock
//   reset_btn  in   asynchronous active-low reset
//   btn_n      in   raw button, active-low, asynchronous to clk
//   press      out  registered 1-cycle press event
// -----------------------------------------------------------------------------
module gol_btn_cond
  import gol_pkg::*;
#(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic reset_btn,
  input  logic btn_n,
  output logic press
);

  localparam int CW = cnt_w(DEBOUNCE);

  logic          sync1_r;
  logic          sync2_r;
  logic          stable_r;
  logic          press_r;
  logic [CW-1:0] cnt_r;
  logic          accept_s;

  // Acceptance happens on the DEBOUNCE-th consecutive sample that differs from the accepted level.
  always_comb begin
    accept_s = 1'b0;
    if ((sync2_r != stable_r) && (cnt_r == CW'(DEBOUNCE - 1))) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
  end

  // Two-flop synchroniser; idles high because the button is active-low.
  always_ff @(posedge clk or negedge reset_btn) begin
    if (!reset_btn) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= btn_n;
      sync2_r <= sync1_r;
    end
  end

  // Debounce counter, accepted level and press pulse.
  always_ff @(posedge clk or negedge reset_btn) begin
    if (!reset_btn) begin
      stable_r <= 1'b1;
      cnt_r    <= {CW{1'b0}};
      press_r  <= 1'b0;
    end else begin
      press_r <= 1'b0;
      if (sync2_r == stable_r) begin
        // Any sample equal to the accepted level restarts the hold count.
        cnt_r <= {CW{1'b0}};
      end else if (accept_s) begin
        stable_r <= sync2_r;
        cnt_r    <= {CW{1'b0}};
        press_r  <= ~sync2_r;
      end else begin
        cnt_r <= cnt_r + CW'(1);
      end
    end
  end

  assign press = press_r;

endmodule

// File: rtl/gol_sequencer.sv
// -----------------------------------------------------------------------------
// gol_sequencer
//   Control FSM for the Game-of-Life board datapath. Conditions the run and
//   load buttons, then issues board clears, row loads and single-generation
//   steps (step_req held until step_ack). Keeps a generation counter that is
//   zeroed by any clear or load.
//   Optional feature macro: GOL_AUTORUN_EN -- when defined, auto_sw=1 makes the
//   sequencer request a step every RUN_PERIOD idle cycles. When undefined,
//   auto_sw is ignored and steps come only from run presses.
// Parameters
//   HEIGHT      board rows including the 1-cell border (interior = HEIGHT-2)
//   DEBOUNCE    button debounce hold, in cycles (>=1)
//   GEN_W       generation counter width
//   RUN_PERIOD  idle cycles between automatic steps (>=1)
// Ports
//   clk        in   system clock
//   reset_btn  in   asynchronous active-low reset
//   run_btn    in   raw run button, active-low
//   load_btn   in   raw load button, active-low
//   auto_sw    in   free-run switch (level)
//   board_clr  out  1-cycle pulse: clear whole board
//   load_en    out  1-cycle pulse: latch data_in into row row_sel+1
//   row_sel    out  interior row index 0..HEIGHT-3
//   step_req   out  generation request, held until step_ack
//   step_ack   in   datapath done pulse (only honoured while step_req=1)
//   gen_count  out  generations completed since last clear/load
//   busy       out  high while a clear or a step is in progress
// -----------------------------------------------------------------------------
module gol_sequencer
  import gol_pkg::*;
#(
  parameter  int HEIGHT     = 5,
  parameter  int DEBOUNCE   = 4,
  parameter  int GEN_W      = 16,
  parameter  int RUN_PERIOD = 8,
  localparam int RW         = row_idx_w(HEIGHT)
) (
  input  logic             clk,
  input  logic             reset_btn,
  input  logic             run_btn,
  input  logic             load_btn,
  input  logic             auto_sw,
  output logic             board_clr,
  output logic             load_en,
  output logic [RW-1:0]    row_sel,
  output logic             step_req,
  input  logic             step_ack,
  output logic [GEN_W-1:0] gen_count,
  output logic             busy
);

  gol_seq_state_t   state_r;
  logic             board_clr_r;
  logic             load_en_r;
  logic             step_req_r;
  logic             busy_r;
  logic [RW-1:0]    row_sel_r;
  logic [GEN_W-1:0] gen_r;
  logic             run_press_s;
  logic             load_press_s;
  logic             auto_hit_s;

  gol_btn_cond #(.DEBOUNCE(DEBOUNCE)) u_run_cond (
    .clk      (clk),
    .reset_btn(reset_btn),
    .btn_n    (run_btn),
    .press    (run_press_s)
  );

  gol_btn_cond #(.DEBOUNCE(DEBOUNCE)) u_load_cond (
    .clk      (clk),
    .reset_btn(reset_btn),
    .btn_n    (load_btn),
    .press    (load_press_s)
  );

`ifdef GOL_AUTORUN_EN
  localparam int PW = cnt_w(RUN_PERIOD);

  logic [PW-1:0] period_r;

  // Period hit decode from the registered auto-run timer.
  always_comb begin
    auto_hit_s = 1'b0;
    if (auto_sw && (state_r == IDLE) && (period_r == PW'(RUN_PERIOD - 1))) begin
      auto_hit_s = 1'b1;
    end else begin
      auto_hit_s = 1'b0;
    end
  end

  // Auto-run timer: counts idle cycles with auto_sw set; restarts on hit, switch off or leaving IDLE.
  always_ff @(posedge clk or negedge reset_btn) begin
    if (!reset_btn) begin
      period_r <= {PW{1'b0}};
    end else if ((state_r != IDLE) || !auto_sw || auto_hit_s) begin
      period_r <= {PW{1'b0}};
    end else begin
      period_r <= period_r + PW'(1);
    end
  end
`else
  logic unused_auto_s;

  assign auto_hit_s    = 1'b0;
  assign unused_auto_s = auto_sw & ((RUN_PERIOD >= 1) ? 1'b1 : 1'b0);
`endif

  // Sequencer FSM; outputs are registered together with the state they belong to.
  always_ff @(posedge clk or negedge reset_btn) begin
    if (!reset_btn) begin
      state_r     <= CLEAR;
      board_clr_r <= 1'b0;
      load_en_r   <= 1'b0;
      step_req_r  <= 1'b0;
      busy_r      <= 1'b0;
      row_sel_r   <= {RW{1'b0}};
      gen_r       <= {GEN_W{1'b0}};
    end else begin
      board_clr_r <= 1'b0;
      load_en_r   <= 1'b0;
      busy_r      <= 1'b0;
      case (state_r)
        CLEAR: begin
          board_clr_r <= 1'b1;
          busy_r      <= 1'b1;
          row_sel_r   <= {RW{1'b0}};
          gen_r       <= {GEN_W{1'b0}};
          state_r     <= IDLE;
        end
        IDLE: begin
          // Load has priority; a simultaneous run press is simply lost.
          if (load_press_s) begin
            load_en_r <= 1'b1;
            state_r   <= LOAD;
          end else if (run_press_s || auto_hit_s) begin
            step_req_r <= 1'b1;
            busy_r     <= 1'b1;
            state_r    <= STEP_REQ;
          end else begin
            state_r <= IDLE;
          end
        end
        LOAD: begin
          gen_r <= {GEN_W{1'b0}};
          if (row_sel_r == RW'(HEIGHT - 3)) begin
            row_sel_r <= {RW{1'b0}};
          end else begin
            row_sel_r <= row_sel_r + RW'(1);
          end
          state_r <= IDLE;
        end
        STEP_REQ: begin
          if (step_ack) begin
            step_req_r <= 1'b0;
            gen_r      <= gen_r + GEN_W'(1);
            state_r    <= IDLE;
          end else begin
            busy_r  <= 1'b1;
            state_r <= STEP_REQ;
          end
        end
        default: begin
          step_req_r <= 1'b0;
          state_r    <= CLEAR;
        end
      endcase
    end
  end

  assign board_clr = board_clr_r;
  assign load_en   = load_en_r;
  assign row_sel   = row_sel_r;
  assign step_req  = step_req_r;
  assign gen_count = gen_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_gol_sequencer.sv
// Scoreboard bench for gol_sequencer (HEIGHT=5, DEBOUNCE=4, RUN_PERIOD=8).
// Stimulus pushes the expected output events; the monitor pops and compares
// whenever board_clr, load_en or a step_req rising edge appears.
module tb_gol_sequencer;

  localparam int K_CLR  = 0;
  localparam int K_LOAD = 1;
  localparam int K_STEP = 2;

  typedef struct {
    int kind;
    int row;
    int gen;
  } exp_t;

  logic        clk;
  logic        reset_btn;
  logic        run_btn;
  logic        load_btn;
  logic        auto_sw;
  logic        board_clr;
  logic        load_en;
  logic [1:0]  row_sel;
  logic        step_req;
  logic        step_ack;
  logic [15:0] gen_count;
  logic        busy;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  logic prev_sr = 1'b0;
  bit   ack_en = 1'b1;
  int   cyc_cnt = 0;

  gol_sequencer #(.HEIGHT(5), .DEBOUNCE(4), .GEN_W(16), .RUN_PERIOD(8)) dut (
    .clk      (clk),
    .reset_btn(reset_btn),
    .run_btn  (run_btn),
    .load_btn (load_btn),
    .auto_sw  (auto_sw),
    .board_clr(board_clr),
    .load_en  (load_en),
    .row_sel  (row_sel),
    .step_req (step_req),
    .step_ack (step_ack),
    .gen_count(gen_count),
    .busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: actual %0d required %0d", nm, act, req);
    end
  endtask

  task automatic push(input int kind, input int row, input int gen);
    exp_t e;
    e.kind = kind;
    e.row  = row;
    e.gen  = gen;
    exp_q.push_back(e);
  endtask

  task automatic sb_event(input int kind);
    exp_t e;
    bit   ok;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL sb_unexpected: actual event kind %0d row %0d gen %0d, required none",
               kind, row_sel, gen_count);
    end else begin
      e  = exp_q.pop_front();
      ok = (e.kind == kind);
      if (kind == K_CLR)  ok = ok && (row_sel == 2'd0) && (gen_count == 16'd0) && busy;
      if (kind == K_LOAD) ok = ok && (int'(row_sel) == e.row) && !busy;
      if (kind == K_STEP) ok = ok && (int'(gen_count) == e.gen) && busy;
      if (!ok) begin
        fails++;
        $display("FAIL sb_event: actual kind %0d row %0d gen %0d busy %0d, required kind %0d row %0d gen %0d",
                 kind, row_sel, gen_count, busy, e.kind, e.row, e.gen);
      end
    end
  endtask

  // Monitor: compare every output event against the scoreboard queue.
  always @(negedge clk) begin
    if (board_clr) sb_event(K_CLR);
    if (load_en) sb_event(K_LOAD);
    if (step_req && !prev_sr) sb_event(K_STEP);
    prev_sr <= step_req;
  end

  // Datapath model: acknowledge 3 cycles after step_req rises.
  initial begin
    step_ack = 1'b0;
    forever begin
      @(posedge step_req);
      if (ack_en) begin
        repeat (3) @(posedge clk);
        #1;
        if (step_req) begin
          step_ack = 1'b1;
          @(posedge clk);
          #1;
          step_ack = 1'b0;
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input bit ld, input bit rn, input int low);
    if (ld) load_btn = 1'b0;
    if (rn) run_btn = 1'b0;
    cyc(low);
    load_btn = 1'b1;
    run_btn  = 1'b1;
  endtask

  task automatic drain(input string nm, input int n);
    cyc(n);
    @(negedge clk);
    check(nm, exp_q.size(), 0);
  endtask

  task automatic wait_level(input logic lvl, output bit ok, output int t);
    ok = 1'b0;
    t  = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (step_req == lvl) begin
        ok = 1'b1;
        t  = cyc_cnt;
      end
    end
  endtask

  initial begin
    bit ok;
    int t0;
    int t1;
    int busy_n;

    reset_btn = 1'b0;
    run_btn   = 1'b1;
    load_btn  = 1'b1;
    auto_sw   = 1'b0;

    // Reset state
    cyc(3);
    @(negedge clk);
    check("rst_board_clr", board_clr, 0);
    check("rst_step_req", step_req, 0);
    check("rst_busy", busy, 0);
    check("rst_row_sel", row_sel, 0);
    check("rst_gen", gen_count, 0);

    // Release: exactly one clear pulse, busy for one cycle
    push(K_CLR, 0, 0);
    @(posedge clk);
    #1 reset_btn = 1'b1;
    busy_n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (busy) busy_n++;
    end
    check("clr_busy_cycles", busy_n, 1);
    drain("clr_drain", 2);

    // Four loads: rows 0,1,2 then wrap to 0
    for (int i = 0; i < 4; i++) begin
      push(K_LOAD, i % 3, 0);
      press(1'b1, 1'b0, 10);
      drain("load_drain", 10);
    end
    check("load_row_after_wrap", row_sel, 1);

    // Bounce: 1-cycle glitches and a 3-cycle low give nothing
    for (int i = 0; i < 3; i++) begin
      press(1'b1, 1'b0, 1);
      cyc(1);
    end
    cyc(8);
    press(1'b1, 1'b0, 3);
    drain("bounce_drain", 15);
    check("bounce_row", row_sel, 1);

    // 6-cycle low: exactly one event
    push(K_LOAD, 1, 0);
    press(1'b1, 1'b0, 6);
    drain("six_low_drain", 15);
    check("six_low_row", row_sel, 2);

    // Ten runs
    for (int i = 0; i < 10; i++) begin
      push(K_STEP, 0, i);
      press(1'b0, 1'b1, 10);
      drain("run_drain", 10);
    end
    check("run_gen10", gen_count, 10);

    // Run press while a step is outstanding is dropped
    ack_en = 1'b0;
    push(K_STEP, 0, 10);
    press(1'b0, 1'b1, 10);
    wait_level(1'b1, ok, t0);
    check("hold_step_rise", ok, 1);
    cyc(10);
    press(1'b0, 1'b1, 10);
    cyc(10);
    check("hold_step_req", step_req, 1);
    check("hold_gen", gen_count, 10);
    step_ack = 1'b1;
    cyc(1);
    step_ack = 1'b0;
    drain("hold_drain", 20);
    check("hold_gen_after", gen_count, 11);
    check("hold_req_low", step_req, 0);
    ack_en = 1'b1;

    // Both buttons: load wins, counter zeroed, row wraps 2 -> 0
    push(K_LOAD, 2, 0);
    press(1'b1, 1'b1, 10);
    drain("both_drain", 20);
    check("both_gen", gen_count, 0);
    check("both_row", row_sel, 0);

    // Stray ack while idle is ignored
    step_ack = 1'b1;
    cyc(1);
    step_ack = 1'b0;
    cyc(2);
    @(negedge clk);
    check("stray_ack_gen", gen_count, 0);

`ifdef GOL_AUTORUN_EN
    // Auto-run: step every 8 idle + 4 handshake cycles, stops with the switch
    push(K_STEP, 0, 0);
    push(K_STEP, 0, 1);
    push(K_STEP, 0, 2);
    #1 auto_sw = 1'b1;
    wait_level(1'b1, ok, t0);
    check("auto_rise1", ok, 1);
    wait_level(1'b0, ok, t1);
    wait_level(1'b1, ok, t1);
    check("auto_rise2", ok, 1);
    check("auto_period_a", t1 - t0, 12);
    t0 = t1;
    wait_level(1'b0, ok, t1);
    wait_level(1'b1, ok, t1);
    check("auto_rise3", ok, 1);
    check("auto_period_b", t1 - t0, 12);
    wait_level(1'b0, ok, t1);
    auto_sw = 1'b0;
    drain("auto_off_drain", 60);
    check("auto_gen", gen_count, 3);
`else
    // Without the auto-run feature the switch has no effect
    auto_sw = 1'b1;
    drain("auto_ignored_drain", 100);
    auto_sw = 1'b0;
    check("auto_ignored_gen", gen_count, 0);
`endif

    // Reset during a step drops step_req immediately, then one clear
    ack_en = 1'b0;
`ifdef GOL_AUTORUN_EN
    push(K_STEP, 0, 3);
`else
    push(K_STEP, 0, 0);
`endif
    press(1'b0, 1'b1, 10);
    wait_level(1'b1, ok, t0);
    check("midrst_step_rise", ok, 1);
    cyc(1);
    reset_btn = 1'b0;
    #1;
    check("midrst_step_req", step_req, 0);
    check("midrst_busy", busy, 0);
    push(K_CLR, 0, 0);
    cyc(3);
    reset_btn = 1'b1;
    ack_en = 1'b1;
    drain("midrst_drain", 10);
    check("midrst_gen", gen_count, 0);
    check("midrst_row", row_sel, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
